// File: rtl/word_align_pkg.sv
// Shared types and helpers for the word-align gearbox and its window selector.
package word_align_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  localparam logic [31:0] DEFAULT_TRAIN_PAT = 32'h0000_0FC0;

  // Bit width needed to index 'value' items; never returns less than 1.
  function automatic int clog2_safe(input int value);
    int bits;
    bits = 1;
    while ((32'sd1 << bits) < value) bits = bits + 1;
    return bits;
  endfunction

endpackage

// File: rtl/word_align_gearbox_if.sv
// Lane-side bus of the word-align gearbox: deserializer input, aligned output and status.
interface word_align_gearbox_if #(
  parameter int IN_W  = 6,
  parameter int RATIO = 2
);
  localparam int OUT_W = IN_W * RATIO;

  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             align_en;
  logic             realign;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             locked;
  logic             search_fail;

  modport master (
    output in_data, in_valid, align_en, realign,
    input  data_out, data_valid, locked, search_fail
  );

  modport slave (
    input  in_data, in_valid, align_en, realign,
    output data_out, data_valid, locked, search_fail
  );
endinterface

// File: rtl/barrel_window.sv
// Selects a W-bit window from a 2W-bit history at a bit offset counted from the MSB,
// and registers it as the output word on each load.
module barrel_window #(
  parameter int W     = 12,
  parameter int OFF_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2*W-1:0]   hist,
  input  logic [OFF_W-1:0] offset,
  input  logic             load,
  output logic [W-1:0]     win,
  output logic [W-1:0]     data_q,
  output logic             valid_q
);

  logic [W-1:0] data_d;
  logic         valid_d;

  always_comb begin
    win     = W'(hist >> (W - int'(offset)));
    valid_d = load;
    if (load) data_d = win;
    else      data_d = data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/word_align_gearbox.sv
// Receive gearbox and autonomous word aligner for one LVDS lane.
// Defining ALIGN_DEBUG_EN adds the dbg_offset and dbg_loss_cnt outputs.
module word_align_gearbox
  import word_align_pkg::*;
#(
  parameter int          IN_W      = 6,
  parameter int          RATIO     = 2,
  parameter logic [31:0] TRAIN_PAT = DEFAULT_TRAIN_PAT,
  parameter int          LOCK_CNT  = 16,
  parameter int          ERR_MAX   = 4
) (
  input  logic clk,
  input  logic reset,
  word_align_gearbox_if.slave bus
`ifdef ALIGN_DEBUG_EN
  ,
  output logic [clog2_safe(IN_W*RATIO)-1:0] dbg_offset,
  output logic [7:0]                        dbg_loss_cnt
`endif
);

  localparam int               OUT_W      = IN_W * RATIO;
  localparam int               OFF_W      = clog2_safe(OUT_W);
  localparam int               PH_W       = clog2_safe(RATIO);
  localparam logic [OUT_W-1:0] PAT        = TRAIN_PAT[OUT_W-1:0];
  localparam logic [OFF_W-1:0] LAST_OFF   = OFF_W'(OUT_W - 1);
  localparam logic [PH_W-1:0]  LAST_PH    = PH_W'(RATIO - 1);
  localparam logic [OFF_W:0]   SWEEP_LAST = (OFF_W + 1)'(OUT_W - 1);
  localparam logic [7:0]       LOCK_TGT   = 8'(LOCK_CNT);
  localparam logic [7:0]       ERR_TGT    = 8'(ERR_MAX);

  align_state_e     state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d, phase_base_s;
  logic [OUT_W-1:0] cur_q, cur_d, prev_q, prev_d, cur_next_s, win_s;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [OFF_W:0]   sweep_cnt_q, sweep_cnt_d;
  logic [7:0]       match_cnt_q, match_cnt_d, err_cnt_q, err_cnt_d;
  logic             skip_q, skip_d, search_fail_q, search_fail_d, locked_q, locked_d;
  logic             word_evt_s, step_s;
  logic [2*OUT_W-1:0] hist_s;

  barrel_window #(.W(OUT_W), .OFF_W(OFF_W)) u_window (
    .clk     (clk),
    .reset   (reset),
    .hist    (hist_s),
    .offset  (offset_q),
    .load    (word_evt_s),
    .win     (win_s),
    .data_q  (bus.data_out),
    .valid_q (bus.data_valid)
  );

  always_comb begin
    phase_d       = phase_q;
    cur_d         = cur_q;
    prev_d        = prev_q;
    offset_d      = offset_q;
    skip_d        = skip_q;
    state_d       = state_q;
    match_cnt_d   = match_cnt_q;
    err_cnt_d     = err_cnt_q;
    sweep_cnt_d   = sweep_cnt_q;
    search_fail_d = search_fail_q;
    word_evt_s    = 1'b0;
    step_s        = 1'b0;
    cur_next_s    = OUT_W'({cur_q, bus.in_data});
    hist_s        = {prev_q, cur_next_s};

    // realign restarts the word boundary; a coincident in_data opens the new word
    if (bus.realign) begin
      state_d       = ST_SEARCH;
      match_cnt_d   = 8'd0;
      err_cnt_d     = 8'd0;
      sweep_cnt_d   = '0;
      search_fail_d = 1'b0;
      phase_base_s  = '0;
    end else begin
      phase_base_s  = phase_q;
    end

    if (bus.in_valid) begin
      cur_d = cur_next_s;
      if (phase_base_s == LAST_PH) begin
        phase_d    = '0;
        prev_d     = cur_next_s;
        word_evt_s = 1'b1;
      end else begin
        phase_d    = phase_base_s + PH_W'(1);
      end
    end else begin
      phase_d = phase_base_s;
    end

    // The first word after an offset move straddles the old boundary, so it is not judged
    if (word_evt_s && skip_q) begin
      skip_d = 1'b0;
    end else if (word_evt_s && bus.align_en && !bus.realign) begin
      case (state_q)
        ST_SEARCH: begin
          if (win_s == PAT) begin
            sweep_cnt_d = '0;
            match_cnt_d = 8'd1;
            state_d     = (LOCK_TGT == 8'd1) ? ST_LOCKED : ST_VERIFY;
          end else begin
            step_s = 1'b1;
            if (sweep_cnt_q == SWEEP_LAST) begin
              sweep_cnt_d   = '0;
              search_fail_d = 1'b1;
            end else begin
              sweep_cnt_d   = sweep_cnt_q + (OFF_W + 1)'(1);
            end
          end
        end
        ST_VERIFY: begin
          if (win_s == PAT) begin
            match_cnt_d = match_cnt_q + 8'd1;
            if (match_cnt_q + 8'd1 == LOCK_TGT) state_d = ST_LOCKED;
            else                                state_d = ST_VERIFY;
          end else begin
            state_d     = ST_SEARCH;
            match_cnt_d = 8'd0;
            step_s      = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (win_s == PAT) begin
            err_cnt_d = 8'd0;
          end else if (err_cnt_q + 8'd1 == ERR_TGT) begin
            state_d   = ST_SEARCH;
            err_cnt_d = 8'd0;
            step_s    = 1'b1;
          end else begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end else begin
      skip_d = skip_q;
    end

    if (step_s) begin
      offset_d = (offset_q == LAST_OFF) ? '0 : offset_q + OFF_W'(1);
      skip_d   = 1'b1;
    end else begin
      offset_d = offset_q;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SEARCH;
      phase_q       <= '0;
      cur_q         <= '0;
      prev_q        <= '0;
      offset_q      <= '0;
      skip_q        <= 1'b0;
      match_cnt_q   <= 8'd0;
      err_cnt_q     <= 8'd0;
      sweep_cnt_q   <= '0;
      search_fail_q <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      cur_q         <= cur_d;
      prev_q        <= prev_d;
      offset_q      <= offset_d;
      skip_q        <= skip_d;
      match_cnt_q   <= match_cnt_d;
      err_cnt_q     <= err_cnt_d;
      sweep_cnt_q   <= sweep_cnt_d;
      search_fail_q <= search_fail_d;
      locked_q      <= locked_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.search_fail = search_fail_q;

`ifdef ALIGN_DEBUG_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Only error-driven drops out of LOCKED count; realign exits are deliberate
  always_comb begin
    if (state_q == ST_LOCKED && state_d == ST_SEARCH && !bus.realign && loss_cnt_q != 8'hFF)
      loss_cnt_d = loss_cnt_q + 8'd1;
    else
      loss_cnt_d = loss_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) loss_cnt_q <= 8'd0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign dbg_offset   = offset_q;
  assign dbg_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_word_align_gearbox.sv
// Randomised bench for word_align_gearbox: default lane checked cycle by cycle against a
// bit-level reference model, plus a wide 8x4 lane checked for lock at offset 17.
module tb_word_align_gearbox;
  import word_align_pkg::*;

  localparam int          IN_W      = 6;
  localparam int          RATIO     = 2;
  localparam int          OUT_W     = 12;
  localparam int          LOCK_CNT  = 16;
  localparam int          ERR_MAX   = 4;
  localparam int          TRAIN_OFF = 5;
  localparam logic [31:0] PAT       = 32'h0000_0FC0;
  localparam logic [31:0] MASK      = 32'h0000_0FFF;
  localparam int          IN_W2     = 8;
  localparam int          RATIO2    = 4;
  localparam int          OFF2      = 17;
  localparam logic [31:0] PAT2      = 32'hFFFF_0000;
  localparam int          M_SEARCH  = 0;
  localparam int          M_VERIFY  = 1;
  localparam int          M_LOCKED  = 2;

  logic clk;
  logic reset;
  logic reset2;
  int   checks   = 0;
  int   failures = 0;

  word_align_gearbox_if #(.IN_W(IN_W),  .RATIO(RATIO))  bus ();
  word_align_gearbox_if #(.IN_W(IN_W2), .RATIO(RATIO2)) bus2 ();

`ifdef ALIGN_DEBUG_EN
  logic [3:0] dbg_offset;
  logic [7:0] dbg_loss_cnt;
  logic [4:0] dbg_offset2;
  logic [7:0] dbg_loss_cnt2;
`endif

  word_align_gearbox #(
    .IN_W(IN_W), .RATIO(RATIO), .TRAIN_PAT(PAT), .LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef ALIGN_DEBUG_EN
    ,
    .dbg_offset   (dbg_offset),
    .dbg_loss_cnt (dbg_loss_cnt)
`endif
  );

  word_align_gearbox #(
    .IN_W(IN_W2), .RATIO(RATIO2), .TRAIN_PAT(PAT2), .LOCK_CNT(LOCK_CNT), .ERR_MAX(ERR_MAX)
  ) dut2 (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
`ifdef ALIGN_DEBUG_EN
    ,
    .dbg_offset   (dbg_offset2),
    .dbg_loss_cnt (dbg_loss_cnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the default lane
  logic [31:0] m_prev, m_cur, m_dout;
  int          m_phase, m_off, m_state, m_match, m_err, m_sweep, m_loss;
  bit          m_skip, m_fail, m_dv;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] v, input int k, input int w);
    logic [63:0] m, v64;
    m   = (64'd1 << w) - 64'd1;
    v64 = {32'd0, v};
    return 32'(((v64 >> k) | (v64 << (w - k))) & m);
  endfunction

  task automatic model_advance();
    m_off  = (m_off + 1) % OUT_W;
    m_skip = 1'b1;
  endtask

  task automatic model_judge(input bit match);
    case (m_state)
      M_SEARCH: begin
        if (match) begin
          m_sweep = 0;
          m_match = 1;
          m_state = (LOCK_CNT == 1) ? M_LOCKED : M_VERIFY;
        end else begin
          model_advance();
          m_sweep++;
          if (m_sweep == OUT_W) begin
            m_fail  = 1'b1;
            m_sweep = 0;
          end
        end
      end
      M_VERIFY: begin
        if (match) begin
          m_match++;
          if (m_match == LOCK_CNT) m_state = M_LOCKED;
        end else begin
          m_state = M_SEARCH;
          m_match = 0;
          model_advance();
        end
      end
      default: begin
        if (match) m_err = 0;
        else begin
          m_err++;
          if (m_err == ERR_MAX) begin
            m_state = M_SEARCH;
            m_err   = 0;
            model_advance();
            if (m_loss < 255) m_loss++;
          end
        end
      end
    endcase
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit ae, input bit ra, input bit rs);
    logic [63:0] hist;
    logic [31:0] win;
    if (rs) begin
      m_prev = '0; m_cur = '0; m_dout = '0; m_phase = 0; m_off = 0; m_state = M_SEARCH;
      m_match = 0; m_err = 0; m_sweep = 0; m_loss = 0; m_skip = 0; m_fail = 0; m_dv = 0;
      return;
    end
    m_dv = 1'b0;
    if (ra) begin
      m_state = M_SEARCH; m_match = 0; m_err = 0; m_sweep = 0; m_fail = 1'b0; m_phase = 0;
    end
    if (v) begin
      m_cur = ((m_cur << IN_W) | d) & MASK;
      m_phase++;
      if (m_phase == RATIO) begin
        m_phase = 0;
        hist    = ({32'd0, m_prev} << OUT_W) | {32'd0, m_cur};
        win     = 32'(hist >> (OUT_W - m_off)) & MASK;
        m_dout  = win;
        m_dv    = 1'b1;
        m_prev  = m_cur;
        if (m_skip) m_skip = 1'b0;
        else if (ae && !ra) model_judge(win == PAT);
      end
    end
  endtask

  // One clock of the default lane: drive, advance model, compare just after the edge
  task automatic tick(input bit v, input logic [IN_W-1:0] d, input bit ae, input bit ra, input bit rs);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.align_en = ae;
    bus.realign  = ra;
    reset        = rs;
    model_step(v, 32'(d), ae, ra, rs);
    @(posedge clk);
    #1;
    check_value("data_valid", 64'(bus.data_valid), 64'(m_dv));
    if (m_dv) check_value("data_out", 64'(bus.data_out), 64'(m_dout));
    check_value("locked", 64'(bus.locked), 64'(m_state == M_LOCKED));
    check_value("search_fail", 64'(bus.search_fail), 64'(m_fail));
`ifdef ALIGN_DEBUG_EN
    check_value("dbg_offset", 64'(dbg_offset), 64'(m_off));
    check_value("dbg_loss_cnt", 64'(dbg_loss_cnt), 64'(m_loss));
`endif
  endtask

  task automatic feed_word(input logic [31:0] w, input bit ae, input int gap_max);
    int gaps;
    for (int i = RATIO - 1; i >= 0; i--) begin
      gaps = $urandom_range(gap_max, 0);
      repeat (gaps) tick(1'b0, 6'($urandom), ae, 1'b0, 1'b0);
      tick(1'b1, 6'(w >> (i * IN_W)), ae, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [31:0] bad_word(input logic [31:0] good);
    return good ^ (32'($urandom_range(31, 1)) << 7);
  endfunction

  initial begin
    logic [31:0] qa, q2;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.align_en = 1'b0; bus.realign = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.align_en = 1'b0; bus2.realign = 1'b0;
    reset = 1'b1; reset2 = 1'b1;
    qa = rotr(PAT, TRAIN_OFF, OUT_W);

    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_value("rst_data_out", 64'(bus.data_out), 64'd0);
    check_value("rst_data_valid", 64'(bus.data_valid), 64'd0);
    check_value("rst_locked", 64'(bus.locked), 64'd0);
    check_value("rst_search_fail", 64'(bus.search_fail), 64'd0);

    repeat (34) feed_word(qa, 1'b1, 1);
    check_value("train_locked", 64'(bus.locked), 64'd1);
    check_value("train_data_out", 64'(bus.data_out), 64'(PAT));

    repeat (3) feed_word(bad_word(qa), 1'b1, 1);
    feed_word(qa, 1'b1, 1);
    check_value("three_errors_stay_locked", 64'(bus.locked), 64'd1);

    repeat (4) feed_word(bad_word(qa), 1'b1, 1);
    check_value("four_errors_lose_lock", 64'(bus.locked), 64'd0);
`ifdef ALIGN_DEBUG_EN
    check_value("loss_offset", 64'(dbg_offset), 64'd6);
    check_value("loss_count", 64'(dbg_loss_cnt), 64'd1);
`endif

    repeat (50) feed_word(qa, 1'b1, 1);
    check_value("relock_after_wrap", 64'(bus.locked), 64'd1);
    check_value("relock_data_out", 64'(bus.data_out), 64'(PAT));

    tick(1'b0, '0, 1'b1, 1'b1, 1'b0);
    repeat (60) feed_word(32'($urandom) & MASK, 1'b1, 1);
    check_value("sweep_search_fail", 64'(bus.search_fail), 64'(m_fail));

    tick(1'b1, 6'($urandom), 1'b1, 1'b1, 1'b0);
    check_value("realign_clears_fail", 64'(bus.search_fail), 64'd0);
    check_value("realign_unlocked", 64'(bus.locked), 64'd0);
    tick(1'b1, 6'($urandom), 1'b1, 1'b0, 1'b0);
    check_value("realign_first_word", 64'(bus.data_valid), 64'd1);

    repeat (50) feed_word(qa, 1'b1, 1);
    check_value("relock_before_data_mode", 64'(bus.locked), 64'd1);
    repeat (20) feed_word(32'($urandom) & MASK, 1'b0, 1);
    check_value("data_mode_holds_lock", 64'(bus.locked), 64'd1);
`ifdef ALIGN_DEBUG_EN
    check_value("data_mode_offset", 64'(dbg_offset), 64'(TRAIN_OFF));
`endif

    repeat (4) begin
      tick(1'b1, 6'($urandom), 1'b0, 1'b0, 1'b0);
      repeat (3) tick(1'b0, 6'($urandom), 1'b0, 1'b0, 1'b0);
    end

    tick(1'b1, 6'($urandom), 1'b0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check_value("midword_rst_data_out", 64'(bus.data_out), 64'd0);
    check_value("midword_rst_locked", 64'(bus.locked), 64'd0);
    tick(1'b1, 6'($urandom), 1'b0, 1'b0, 1'b0);
    check_value("fresh_word_half", 64'(bus.data_valid), 64'd0);
    tick(1'b1, 6'($urandom), 1'b0, 1'b0, 1'b0);
    check_value("fresh_word_full", 64'(bus.data_valid), 64'd1);

    // Wide lane: stream a constant word whose aligned view sits at bit offset 17
    @(negedge clk);
    bus.in_valid  = 1'b0;
    reset2        = 1'b0;
    bus2.align_en = 1'b1;
    q2 = rotr(PAT2, OFF2, 32);
    for (int w = 0; w < 60; w++) begin
      for (int i = RATIO2 - 1; i >= 0; i--) begin
        @(negedge clk);
        bus2.in_valid = 1'b1;
        bus2.in_data  = 8'(q2 >> (i * IN_W2));
      end
    end
    @(negedge clk);
    bus2.in_valid = 1'b0;
    check_value("wide_locked", 64'(bus2.locked), 64'd1);
    check_value("wide_data_valid", 64'(bus2.data_valid), 64'd1);
    check_value("wide_data_out", 64'(bus2.data_out), 64'(PAT2));
`ifdef ALIGN_DEBUG_EN
    check_value("wide_offset", 64'(dbg_offset2), 64'(OFF2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_align_gearbox.md
Name: word_align_gearbox

Overview:
- Parametrised next-generation receive gearbox and word aligner for one LVDS data lane, operating on the parallel output of a 1:IN_W deserializer.
- Packs RATIO consecutive IN_W-bit words into one OUT_W-bit word, MSB first.
- Finds word alignment autonomously against a training pattern using a bit-offset barrel window, so no external bitslip sequencing is needed.
- Holds the offset during data mode and reports lock and loss of lock.

Parameters:
- IN_W, 6, deserializer parallel width.
- RATIO, 2, input words per output word; OUT_W = IN_W*RATIO (localparam, max 32).
- TRAIN_PAT, 12'hFC0, training word, OUT_W bits.
- LOCK_CNT, 16, consecutive matches required to declare lock (range 1..255).
- ERR_MAX, 4, consecutive mismatches in LOCKED that force re-search (range 1..255).

Ports:
- clk  in  1  word clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  IN_W  deserializer word; bit IN_W-1 is the earliest-received bit.
- in_valid  in  1  in_data qualifier.
- align_en  in  1  1 = training mode (compare and search active); 0 = data mode (offset frozen).
- realign  in  1  single-cycle pulse; forces SEARCH from any state.
- data_out  out  OUT_W  aligned word.
- data_valid  out  1  one-cycle strobe per data_out word.
- locked  out  1  FSM is in LOCKED.
- search_fail  out  1  sticky: a full sweep of all offsets found no match; cleared by reset or realign.

Behaviour:
- Reset values: data_out=0, data_valid=0, locked=0, search_fail=0, phase=0, offset=0, FSM=SEARCH, all counters 0.
- Packing:
  - phase counts 0..RATIO-1 on each in_valid.
  - Each accepted in_data shifts into the cur register from the LSB side.
  - When the RATIO-th word is accepted (phase wraps to 0), prev<=cur_complete and the word event fires.
  - No word event occurs without in_valid; gaps in in_valid are allowed.
- Window: hist={prev,cur} (2*OUT_W bits); win = hist[2*OUT_W-1-offset -: OUT_W] for offset 0..OUT_W-1.
- Output timing: data_out<=win and data_valid=1 on the cycle after each word event. Latency from the accepted completing in_data to data_valid is 1 clk, plus one word of history delay.
- Settle: after any offset change, the next word event produces output but is not compared (skip flag).
- FSM, evaluated on compared word events when align_en=1:
  - SEARCH:
    - win==TRAIN_PAT → VERIFY, match_cnt=1 (LOCK_CNT=1 → LOCKED directly).
    - Mismatch → offset+1; wrap OUT_W-1→0.
    - On wrap, sweep_cnt completes: search_fail<=1 and the search continues.
  - VERIFY:
    - Match → match_cnt+1; reaching LOCK_CNT → LOCKED.
    - Mismatch → SEARCH, offset+1, match_cnt=0.
  - LOCKED:
    - Mismatch → err_cnt+1; reaching ERR_MAX → SEARCH, offset+1, err_cnt=0.
    - Match → err_cnt=0.
- align_en=0: no comparisons and no offset changes. FSM holds its state (LOCKED stays LOCKED); packing and output continue.
- realign=1 (priority over everything but reset):
  - FSM=SEARCH; match_cnt, err_cnt and search_fail cleared; offset retained.
  - phase resets to 0; the partial word is discarded.
  - realign coincident with in_valid: that word is the first word of the new phase.
- reset mid-word: the partial word is discarded and no data_valid is generated on the reset cycle.

Optional Feature:
- ALIGN_DEBUG_EN defined:
  - Adds dbg_offset (out, $clog2(OUT_W)) showing the live offset.
  - Adds dbg_loss_cnt (out, 8): saturating count of LOCKED→SEARCH transitions caused by errors; reset to 0, cleared by reset only.
- Undefined: neither port exists and no extra logic is generated.

Decomposition:
- Shared package word_align_pkg holds:
  - FSM state typedef (SEARCH, VERIFY, LOCKED).
  - Offset width function clog2_safe.
  - Default TRAIN_PAT constant.
- One sub-module: barrel_window. This is a combinational window select from hist by offset, registered at the output, and is reusable by other lane widths.

Test Plan:
- Stream TRAIN_PAT pre-shifted so alignment is offset 5 (defaults) → offsets 0..5 stepped with one skip each; VERIFY at offset 5; locked=1 after 16 matches; dbg_offset=5.
- Locked, inject 3 corrupted words then a good one → stays locked, err_cnt returns to 0. Inject 4 consecutive bad words → locked=0, offset=6, re-search re-locks at 5 after wrap.
- Random data (no pattern) for 3*12 word events → search_fail=1 after the first full sweep. realign pulse → search_fail=0, phase=0.
- Locked, align_en=0, feed random data → locked stays 1, offset unchanged, data_valid every 2nd in_valid word, data_out equals the prev/cur window at offset 5.
- in_valid with gaps (1 on, 3 off): data_valid only after every 2nd accepted word; reset asserted after 1 word → outputs 0, next completed word needs 2 fresh in_valids.
- Reconfigure IN_W=8, RATIO=4, TRAIN_PAT=32'hFFFF0000, stream at offset 17 → locks with offset=17 and data_out=32'hFFFF0000 every word.
